// File: rtl/led_mode_controller.sv
// Four-button LED mode controller.
// Each button is synchronized and debounced. A debounced press steps its LED
// through OFF -> ON -> BLINK -> PWM -> OFF. One blink timer and one PWM timer
// run continuously and are shared by all four LEDs.
//
// state       | meaning
// ------------+--------------------------------------------
// MODE_OFF    | LED held low
// MODE_ON     | LED held high
// MODE_BLINK  | LED follows the shared blink phase
// MODE_PWM    | LED follows the shared PWM on-window
module led_mode_controller #(
    parameter int DEBOUNCE_CYCLES   = 1250000,
    parameter int BLINK_HALF_CYCLES = 31250000,
    parameter int PWM_PERIOD        = 256,
    parameter int PWM_DUTY          = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] BTN,
    output logic [3:0] LD,
    output logic [7:0] MODE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam int PW = $clog2(PWM_PERIOD + 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] deb_cnt_q [4];
    logic [CW-1:0] deb_cnt_d [4];
    mode_e         mode_q [4];
    mode_e         mode_d [4];
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic          pwm_on;
    logic [3:0]    ld_q, ld_d;

    // Two-stage synchronizer chain for the raw buttons.
    always_comb begin
        sync1_d = BTN;
        sync2_d = sync1_q;
    end

    // Debounce: count consecutive cycles in which the second synchronizer stage
    // holds a value different from the debounced one. The count is taken on the
    // edge that loads sync2, so a change seen at sync2 is counted from its first
    // cycle; a fresh change in sync2 restarts the run at 1.
    always_comb begin
        logic [CW-1:0] stable_cnt;
        stable_cnt = '0;
        deb_d      = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            stable_cnt   = '0;
            if (sync2_d[i] != deb_q[i]) begin
                stable_cnt = (sync2_q[i] == sync2_d[i]) ? deb_cnt_q[i] + CW'(1) : CW'(1);
                if (stable_cnt == CW'(DEBOUNCE_CYCLES)) begin
                    deb_d[i] = sync2_d[i];
                end else begin
                    deb_cnt_d[i] = stable_cnt;
                end
            end
        end
    end

    // Mode step on a debounced rising edge only; releases leave the mode alone.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mode_d[i] = mode_q[i];
            if (deb_d[i] && !deb_q[i]) begin
                case (mode_q[i])
                    MODE_OFF:   mode_d[i] = MODE_ON;
                    MODE_ON:    mode_d[i] = MODE_BLINK;
                    MODE_BLINK: mode_d[i] = MODE_PWM;
                    MODE_PWM:   mode_d[i] = MODE_OFF;
                    default:    mode_d[i] = MODE_OFF;
                endcase
            end
        end
    end

    // Shared free-running blink and PWM timers, independent of any mode.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(BLINK_HALF_CYCLES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        pwm_cnt_d = pwm_cnt_q + PW'(1);
        if (pwm_cnt_q == PW'(PWM_PERIOD - 1)) begin
            pwm_cnt_d = '0;
        end
        pwm_on = (pwm_cnt_q < PW'(PWM_DUTY));
    end

    // LED drive decoded from the current mode and timer state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ld_d[i] = 1'b0;
            case (mode_q[i])
                MODE_OFF:   ld_d[i] = 1'b0;
                MODE_ON:    ld_d[i] = 1'b1;
                MODE_BLINK: ld_d[i] = blink_phase_q;
                MODE_PWM:   ld_d[i] = pwm_on;
                default:    ld_d[i] = 1'b0;
            endcase
        end
    end

    // State registers; reset discards all debounce, mode and timer progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
            ld_q          <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
                mode_q[i]    <= MODE_OFF;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            ld_q          <= ld_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                mode_q[i]    <= mode_d[i];
            end
        end
    end

    assign LD   = ld_q;
    assign MODE = {mode_q[3], mode_q[2], mode_q[1], mode_q[0]};

endmodule

// File: tb/tb_led_mode_controller.sv
// Bench for led_mode_controller with small timing parameters.
module tb_led_mode_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] BTN;
    logic [3:0] LD;
    logic [7:0] MODE;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_mode_q [$];
    int         exp_m [4];

    always #5 CLK = ~CLK;

    led_mode_controller #(
        .DEBOUNCE_CYCLES  (4),
        .BLINK_HALF_CYCLES(3),
        .PWM_PERIOD       (4),
        .PWM_DUTY         (1)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .BTN (BTN),
        .LD  (LD),
        .MODE(MODE)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] model_mode();
        return {2'(exp_m[3]), 2'(exp_m[2]), 2'(exp_m[1]), 2'(exp_m[0])};
    endfunction

    task automatic do_reset();
        BTN = '0;
        RST = 1'b1;
        #1;
        checks++;
        if (LD !== 4'b0000 || MODE !== 8'h00) begin
            failures++;
            $display("FAIL reset_assert LD=%b MODE=%h expected 0000/00", LD, MODE);
        end
        repeat (3) tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) exp_m[i] = 0;
        exp_mode_q.delete();
    endtask

    // Press (and keep holding) the buttons in mask; expect one MODE step at edge 5.
    task automatic press(input logic [3:0] mask, input string name);
        logic [7:0] prev;
        logic [7:0] exp;
        int         n;
        prev = MODE;
        for (int i = 0; i < 4; i++) if (mask[i]) exp_m[i] = (exp_m[i] + 1) % 4;
        exp_mode_q.push_back(model_mode());
        BTN = BTN | mask;
        n = 0;
        do begin
            tick();
            n++;
        end while (MODE === prev && n < 20);
        exp = exp_mode_q.pop_front();
        checks++;
        if (MODE !== exp) begin
            failures++;
            $display("FAIL %s_mode MODE=%h expected %h", name, MODE, exp);
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL %s_latency edges=%0d expected 5", name, n);
        end
    endtask

    task automatic release_btn(input logic [3:0] mask, input string name);
        logic bad;
        BTN = BTN & ~mask;
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (MODE !== model_mode()) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_release MODE=%h expected %h", name, MODE, model_mode());
        end
    endtask

    task automatic test_reset();
        logic bad;
        do_reset();
        bad = 1'b0;
        repeat (20) begin
            tick();
            checks++;
            if (LD !== 4'b0000 || MODE !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle LD=%b MODE=%h expected 0000/00", LD, MODE);
            end
        end
    endtask

    task automatic test_single_press();
        logic bad;
        do_reset();
        press(4'b0001, "single");
        checks++;
        if (LD !== 4'b0000) begin
            failures++;
            $display("FAIL single_ld_edge5 LD=%b expected 0000", LD);
        end
        tick();
        checks++;
        if (LD !== 4'b0001) begin
            failures++;
            $display("FAIL single_ld_edge6 LD=%b expected 0001", LD);
        end
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (MODE !== 8'h01 || LD !== 4'b0001) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL single_hold LD=%b MODE=%h expected 0001/01", LD, MODE);
        end
        release_btn(4'b0001, "single");
    endtask

    task automatic test_glitch();
        logic bad;
        BTN[1] = 1'b1;
        tick();
        tick();
        BTN[1] = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (MODE !== model_mode()) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL glitch MODE=%h expected %h", MODE, model_mode());
        end
    endtask

    task automatic test_mode_walk();
        logic s [13];
        int   last, cnt;
        logic bad;
        press(4'b0100, "walk_on");
        release_btn(4'b0100, "walk_on");
        press(4'b0100, "walk_blink");
        release_btn(4'b0100, "walk_blink");
        bad = 1'b0;
        for (int k = 0; k < 13; k++) begin
            tick();
            s[k] = LD[2];
            if (LD[0] !== 1'b1) bad = 1'b1;
        end
        last = -1;
        cnt  = 0;
        for (int k = 1; k < 13; k++) begin
            if (s[k] !== s[k-1]) begin
                if (last >= 0 && k - last != 3) bad = 1'b1;
                last = k;
                cnt++;
            end
        end
        checks++;
        if (bad || cnt < 3) begin
            failures++;
            $display("FAIL walk_blink_period toggles=%0d bad=%b expected period 3 and >=3 toggles", cnt, bad);
        end
        press(4'b0100, "walk_pwm");
        release_btn(4'b0100, "walk_pwm");
        bad  = 1'b0;
        last = -1;
        cnt  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (LD[2] === 1'b1) begin
                if (last >= 0 && k - last != 4) bad = 1'b1;
                last = k;
                cnt++;
            end
        end
        checks++;
        if (bad || cnt != 3) begin
            failures++;
            $display("FAIL walk_pwm_duty highs=%0d bad=%b expected 3 highs spaced 4", cnt, bad);
        end
        press(4'b0100, "walk_off");
        release_btn(4'b0100, "walk_off");
        checks++;
        if (LD !== 4'b0001) begin
            failures++;
            $display("FAIL walk_off_ld LD=%b expected 0001", LD);
        end
    endtask

    task automatic test_simultaneous();
        logic bad;
        logic prev0;
        int   cnt;
        do_reset();
        press(4'b1111, "simul");
        release_btn(4'b1111, "simul");
        press(4'b0011, "simul_blink");
        release_btn(4'b0011, "simul_blink");
        bad   = 1'b0;
        cnt   = 0;
        prev0 = LD[0];
        for (int k = 0; k < 12; k++) begin
            tick();
            if (LD[0] !== LD[1] || LD[3:2] !== 2'b11) bad = 1'b1;
            if (LD[0] !== prev0) cnt++;
            prev0 = LD[0];
        end
        checks++;
        if (bad || cnt < 3) begin
            failures++;
            $display("FAIL simul_blink_phase LD=%b toggles=%0d expected LD0==LD1, LD3:2=11, >=3 toggles", LD, cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        press(4'b1110, "mid_a");
        release_btn(4'b1110, "mid_a");
        press(4'b1100, "mid_b");
        release_btn(4'b1100, "mid_b");
        press(4'b1000, "mid_c");
        release_btn(4'b1000, "mid_c");
        BTN[3] = 1'b1;
        tick();
        tick();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (LD !== 4'b0000 || MODE !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_async LD=%b MODE=%h expected 0000/00", LD, MODE);
        end
        repeat (3) tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) exp_m[i] = 0;
        exp_mode_q.delete();
        press(4'b1000, "post_reset");
        bad = 1'b0;
        tick();
        checks++;
        if (LD !== 4'b1000) begin
            failures++;
            $display("FAIL post_reset_ld LD=%b expected 1000", LD);
        end
        repeat (10) begin
            tick();
            if (MODE !== 8'h40) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL post_reset_hold MODE=%h expected 40", MODE);
        end
        release_btn(4'b1000, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_mode_walk();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_mode_controller.md
LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

Interface
REQ-001 The block SHALL have a single clock, CLK, and all sequential logic SHALL be clocked on the rising edge of CLK.
REQ-002 The block SHALL have one reset, RST, which is asynchronous and active-high.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1250000: number of consecutive stable cycles required to accept a button change (10 ms at 125 MHz); legal range >= 1.
REQ-004 Parameter BLINK_HALF_CYCLES, default 31250000: cycles per blink half-period (0.25 s at 125 MHz); legal range >= 1.
REQ-005 Parameter PWM_PERIOD, default 256: PWM period in cycles; legal range >= 2.
REQ-006 Parameter PWM_DUTY, default 32: PWM on-cycles per period; legal range 0..PWM_PERIOD.
REQ-007 Port CLK: input, 1 bit, system clock.
REQ-008 Port RST: input, 1 bit, asynchronous active-high reset.
REQ-009 Port BTN: input, 4 bits, raw asynchronous push buttons, where BTN[i] controls LD[i].
REQ-010 Port LD: output, 4 bits, registered LED drive.
REQ-011 Port MODE: output, 8 bits, registered current mode, with MODE[2i+1:2i] belonging to LED i.

Function
REQ-012 Each BTN[i] SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per-button debounce:
- Counter increments each edge while the synced value differs from the debounced value.
- Counter clears on any edge where the synced value equals the debounced value.
- The debounced value takes the synced value on the edge the count reaches DEBOUNCE_CYCLES; the counter then clears.
REQ-014 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1), and the counter SHALL never wrap.
REQ-015 Per-LED mode state machine, 2 bits: OFF=0, ON=1, BLINK=2, PWM=3.
REQ-016 On the edge where debounced[i] rises 0->1, mode[i] SHALL advance OFF->ON->BLINK->PWM->OFF.
- A debounced fall SHALL not change the mode.
- A held button SHALL advance the mode exactly once.
REQ-017 The four LEDs SHALL be independent; simultaneous presses SHALL advance every pressed LED on the same edge.
REQ-018 Blink timer:
- Free-running counter, 0..BLINK_HALF_CYCLES-1, wrapping to 0.
- blink_phase toggles on each wrap.
- It is shared by all LEDs, so all LEDs in BLINK are in phase.
REQ-019 PWM timer: free-running counter, 0..PWM_PERIOD-1, wrapping to 0; pwm_on = (count < PWM_DUTY).
- PWM_DUTY=0 gives always off; PWM_DUTY=PWM_PERIOD gives always on.
REQ-020 Both timers SHALL run continuously regardless of mode, so a mode change SHALL not restart them.
REQ-021 LD[i] SHALL be registered from the values of the previous edge: OFF->0, ON->1, BLINK->blink_phase, PWM->pwm_on.
REQ-022 MODE SHALL equal the mode registers directly, with zero added latency.
REQ-023 Latency, for BTN[i] rising just after edge 0 and held:
- sync2 high at edge 2;
- debounced and mode change at edge DEBOUNCE_CYCLES+1;
- LD reflects the new mode at edge DEBOUNCE_CYCLES+2.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL cause no mode change.

Reset
REQ-025 While RST=1 the following SHALL be 0, asynchronously and immediately:
- LD and MODE;
- all mode, synchronizer, debounced and counter registers;
- blink_phase.
REQ-026 A reset asserted mid-debounce or mid-blink SHALL discard all progress.
REQ-027 After RST release, a button already held SHALL be debounced from zero and SHALL advance its mode once.
REQ-028 On the first edge after release, all counters SHALL start at 0.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=3, PWM_PERIOD=4, PWM_DUTY=1)
REQ-029 Reset check: after reset, with BTN=0 for 20 cycles -> LD=0000 and MODE=0x00 throughout.
REQ-030 Single press and glitch:
- BTN=0001 held from just after edge 0 -> MODE=0x01 at edge 5, LD=0001 at edge 6, and no further change while held.
- A 2-cycle pulse on BTN[1] -> MODE unchanged.
REQ-031 Mode walk: four clean press/release cycles on BTN[2] -> MODE[5:4] steps 1,2,3,0.
- In BLINK, LD[2] toggles every 3 cycles.
- In PWM, LD[2] is high for 1 of every 4 cycles.
REQ-032 Simultaneous presses: BTN=1111 pressed together from all-OFF -> MODE=0x55 on a single edge; set 2 LEDs to BLINK -> both LEDs toggle on identical edges.
REQ-033 Reset mid-operation:
- Assert RST with MODE=0xE4 while BTN[3] is mid-debounce -> LD=0 and MODE=0 immediately.
- After release, with BTN[3] still held -> MODE=0x40 after 4 stable synced cycles.
